// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One whole transaction is granted at a time; LSU has priority with a bounded-starvation guard for IFU.
module axi_mem_arbiter #(
  parameter int unsigned MAX_LSU_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  // M0: IFU
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  // M1: LSU
  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // Slave port
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  localparam int unsigned CW = $clog2(MAX_LSU_RUN + 1);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] run_cnt, run_cnt_next;
  logic          lsu_req, ifu_req, run_full;

  assign lsu_req  = lsu_arvalid | lsu_awvalid;
  assign ifu_req  = ifu_arvalid;
  assign run_full = (run_cnt == CW'(MAX_LSU_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
    end
  end

  // The run counter only advances while IFU is waiting, so it never exceeds MAX_LSU_RUN.
  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    unique case (state)
      IDLE: begin
        if (lsu_req && (!ifu_req || !run_full)) begin
          state_next = lsu_arvalid ? LSU_RD : LSU_WR;
          if (ifu_req) run_cnt_next = run_cnt + 1'b1;
        end else if (ifu_req) begin
          state_next   = IFU_RD;
          run_cnt_next = '0;
        end
      end
      IFU_RD:  if (s_rvalid && ifu_rready) state_next = IDLE;
      LSU_RD:  if (s_rvalid && lsu_rready) state_next = IDLE;
      LSU_WR:  if (s_bvalid && lsu_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ifu_arready = '0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = '0;
    lsu_arready = '0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = '0;
    lsu_awready = '0;
    lsu_wready  = '0;
    lsu_bresp   = '0;
    lsu_bvalid  = '0;
    s_araddr    = '0;
    s_arvalid   = '0;
    s_rready    = '0;
    s_awaddr    = '0;
    s_awvalid   = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = '0;
    s_bready    = '0;
    unique case (state)
      IFU_RD: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid;
        ifu_arready = s_arready;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid;
        lsu_arready = s_arready;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      LSU_WR: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid;
        lsu_awready = s_awready;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid;
        lsu_wready  = s_wready;
        lsu_bresp   = s_bresp;
        lsu_bvalid  = s_bvalid;
        s_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: behavioural IFU/LSU masters and slave, checked against
// a transaction-order model of the LSU-priority / bounded-starvation rule.
module tb_axi_mem_arbiter;

  localparam int unsigned MAX_RUN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, s_rresp, s_bresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [7:0]  lsu_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;

  axi_mem_arbiter #(.MAX_LSU_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
  } lop_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Master models
  logic [31:0] ifu_q[$];
  lop_t        lsu_q[$];
  bit          ifu_ph, lsu_ar_done, lsu_aw_done, lsu_w_done;
  logic [31:0] ifu_res_addr[$], ifu_res_data[$], lsu_res_data[$];
  logic [1:0]  ifu_res_resp[$], lsu_res_resp[$];

  // Slave model: 0 idle, 1 read latency, 2 collecting AW/W, 3 write latency
  int          sst, scnt, fixed_lat;
  logic [31:0] s_raddr, cap_addr, cap_data;
  logic [7:0]  cap_strb;
  bit          got_aw, got_w, stray_r, stray_b, force_both;
  logic [31:0] grant_log[$], sw_addr[$], sw_data[$];
  logic [7:0]  sw_strb[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    return (a[31:28] == 4'hE) ? 2'd2 : 2'd0;
  endfunction

  function automatic int lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [127:0] mout();
    return 128'({ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rresp,
                 lsu_rvalid, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid});
  endfunction

  function automatic logic [127:0] sout();
    return 128'({s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic models_clear();
    ifu_q.delete(); lsu_q.delete();
    ifu_ph = 0; lsu_ar_done = 0; lsu_aw_done = 0; lsu_w_done = 0;
    sst = 0; scnt = 0; got_aw = 0; got_w = 0;
    stray_r = 0; stray_b = 0; force_both = 0;
  endtask

  task automatic logs_clear();
    ifu_res_addr.delete(); ifu_res_data.delete(); ifu_res_resp.delete();
    lsu_res_data.delete(); lsu_res_resp.delete();
    grant_log.delete(); sw_addr.delete(); sw_data.delete(); sw_strb.delete();
  endtask

  task automatic drive();
    ifu_arvalid = (ifu_q.size() > 0) && !ifu_ph;
    ifu_araddr  = '0;
    if (ifu_arvalid) ifu_araddr = ifu_q[0];
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    lsu_arvalid = 1'b0; lsu_araddr = '0;
    lsu_awvalid = 1'b0; lsu_awaddr = '0;
    lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    if (lsu_q.size() > 0) begin
      if (!lsu_q[0].w) begin
        lsu_arvalid = !lsu_ar_done; lsu_araddr = lsu_q[0].addr;
      end else begin
        lsu_awvalid = !lsu_aw_done; lsu_awaddr = lsu_q[0].addr;
        lsu_wvalid  = !lsu_w_done;  lsu_wdata = lsu_q[0].data; lsu_wstrb = lsu_q[0].strb;
      end
    end
    if (force_both) begin
      lsu_arvalid = 1'b1; lsu_araddr = 32'h9000_0F00;
      lsu_awvalid = 1'b1; lsu_awaddr = 32'h9000_0F80;
      lsu_wvalid  = 1'b1; lsu_wdata  = 32'h1234_5678; lsu_wstrb = 8'hff;
    end
    s_arready = (sst == 0);
    s_awready = ((sst == 0) || (sst == 2)) && !got_aw && ($urandom_range(0, 3) != 0);
    s_wready  = ((sst == 0) || (sst == 2)) && !got_w  && ($urandom_range(0, 3) != 0);
    s_rvalid  = ((sst == 1) && (scnt == 0)) || stray_r;
    s_rdata   = (sst == 1) ? mem_rd(s_raddr) : (stray_r ? 32'hBAD0_0001 : '0);
    s_rresp   = (sst == 1) ? slv_resp(s_raddr) : (stray_r ? 2'd1 : 2'd0);
    s_bvalid  = ((sst == 3) && (scnt == 0)) || stray_b;
    s_bresp   = (sst == 3) ? slv_resp(cap_addr) : (stray_b ? 2'd3 : 2'd0);
  endtask

  // Called at negedge+1: sample handshakes, cross the posedge, update all models, re-drive.
  task automatic cycle();
    bit h_iar, h_ir, h_lar, h_lr, h_law, h_lw, h_lb, h_sar, h_saw, h_sw, h_sr, h_sb;
    logic [31:0] v_ird, v_lrd, v_saa, v_swa, v_swd;
    logic [1:0]  v_irr, v_lrr, v_lbr;
    logic [7:0]  v_sws;
    h_iar = ifu_arvalid & ifu_arready;  h_ir = ifu_rvalid & ifu_rready;
    h_lar = lsu_arvalid & lsu_arready;  h_lr = lsu_rvalid & lsu_rready;
    h_law = lsu_awvalid & lsu_awready;  h_lw = lsu_wvalid & lsu_wready;
    h_lb  = lsu_bvalid & lsu_bready;
    h_sar = s_arvalid & s_arready;      h_saw = s_awvalid & s_awready;
    h_sw  = s_wvalid & s_wready;        h_sr = s_rvalid & s_rready;
    h_sb  = s_bvalid & s_bready;
    v_ird = ifu_rdata; v_irr = ifu_rresp; v_lrd = lsu_rdata; v_lrr = lsu_rresp; v_lbr = lsu_bresp;
    v_saa = s_araddr; v_swa = s_awaddr; v_swd = s_wdata; v_sws = s_wstrb;
    @(negedge clk);
    if (h_iar) ifu_ph = 1;
    if (h_ir) begin
      ifu_res_data.push_back(v_ird); ifu_res_resp.push_back(v_irr);
      if (ifu_q.size() > 0) begin
        ifu_res_addr.push_back(ifu_q[0]);
        void'(ifu_q.pop_front());
      end
      ifu_ph = 0;
    end
    if (h_lar) lsu_ar_done = 1;
    if (h_law) lsu_aw_done = 1;
    if (h_lw)  lsu_w_done = 1;
    if (h_lr || h_lb) begin
      lsu_res_data.push_back(h_lr ? v_lrd : 32'h0);
      lsu_res_resp.push_back(h_lr ? v_lrr : v_lbr);
      if (lsu_q.size() > 0) void'(lsu_q.pop_front());
      lsu_ar_done = 0; lsu_aw_done = 0; lsu_w_done = 0;
    end
    if (sst == 0 && h_sar) begin
      grant_log.push_back(v_saa); s_raddr = v_saa; sst = 1; scnt = lat();
    end else if (sst == 0 || sst == 2) begin
      if (h_saw) begin got_aw = 1; cap_addr = v_swa; grant_log.push_back(v_swa); end
      if (h_sw) begin got_w = 1; cap_data = v_swd; cap_strb = v_sws; end
      if (got_aw || got_w) sst = 2;
      if (got_aw && got_w) begin
        sw_addr.push_back(cap_addr); sw_data.push_back(cap_data); sw_strb.push_back(cap_strb);
        got_aw = 0; got_w = 0; sst = 3; scnt = lat();
      end
    end else if (sst == 1 || sst == 3) begin
      if ((sst == 1 && h_sr) || (sst == 3 && h_sb)) sst = 0;
      else if (scnt > 0) scnt--;
    end
    drive();
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((ifu_q.size() > 0 || lsu_q.size() > 0 || sst != 0) && n < budget) begin
      cycle(); n++;
    end
    chk(tag, 128'(n >= budget), 128'(0));
  endtask

  task automatic apply_reset();
    rst = 1'b1; models_clear(); drive();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] laddr[$], iaddr[$], exp_order[$];
    lop_t        lops[$];
    lop_t        op;
    int          n, c, li, ii;

    fixed_lat = -1;
    rst = 1'b1; models_clear(); logs_clear(); drive();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_master_outs", mout(), 128'(0));
    chk("reset_slave_outs", sout(), 128'(0));
    rst = 1'b0;
    cycle();

    // IFU read only, slave latency 2
    fixed_lat = 2; logs_clear();
    ifu_q.push_back(32'h8000_0000); drive(); #1;
    chk("ifu_bubble_no_arvalid", 128'(s_arvalid), 128'(0));
    cycle();
    chk("ifu_s_arvalid", 128'(s_arvalid), 128'(1));
    chk("ifu_s_araddr", 128'(s_araddr), 128'(32'h8000_0000));
    chk("ifu_arready_fwd", 128'(ifu_arready), 128'(1));
    wait_idle("ifu_rd_timeout", 40);
    chk("ifu_rd_count", 128'(ifu_res_data.size()), 128'(1));
    if (ifu_res_data.size() > 0) begin
      chk("ifu_rdata", 128'(ifu_res_data[0]), 128'(32'h0000_0413));
      chk("ifu_rresp", 128'(ifu_res_resp[0]), 128'(0));
    end
    chk("ifu_rd_back_idle", sout(), 128'(0));

    // LSU write: AW/W reach the slave intact, IFU side stays silent
    fixed_lat = -1; logs_clear();
    op.w = 1; op.addr = 32'h8000_1000; op.data = 32'hDEAD_BEEF; op.strb = 8'h0f;
    lsu_q.push_back(op); drive(); #1;
    n = 0;
    while ((lsu_q.size() > 0 || sst != 0) && n < 40) begin
      chk("wr_ifu_quiet", 128'({ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid}), 128'(0));
      cycle(); n++;
    end
    chk("wr_timeout", 128'(n >= 40), 128'(0));
    chk("wr_slave_count", 128'(sw_addr.size()), 128'(1));
    if (sw_addr.size() > 0) begin
      chk("wr_awaddr", 128'(sw_addr[0]), 128'(32'h8000_1000));
      chk("wr_wdata", 128'(sw_data[0]), 128'(32'hDEAD_BEEF));
      chk("wr_wstrb", 128'(sw_strb[0]), 128'(8'h0f));
    end
    chk("wr_bvalid_fwd_count", 128'(lsu_res_resp.size()), 128'(1));
    if (lsu_res_resp.size() > 0) chk("wr_bresp", 128'(lsu_res_resp[0]), 128'(0));

    // Simultaneous IFU and LSU reads: LSU first, IFU after one bubble
    logs_clear();
    ifu_q.push_back(32'h8000_0040);
    op.w = 0; op.addr = 32'h9000_0100; op.data = '0; op.strb = '0;
    lsu_q.push_back(op); drive(); #1;
    n = 0;
    while (lsu_res_data.size() == 0 && n < 40) begin
      chk("both_ifu_arready_low", 128'(ifu_arready), 128'(0));
      cycle(); n++;
    end
    chk("both_lsu_timeout", 128'(n >= 40), 128'(0));
    chk("both_bubble", 128'(s_arvalid), 128'(0));
    cycle();
    chk("both_ifu_granted", 128'(s_arvalid), 128'(1));
    chk("both_ifu_addr", 128'(s_araddr), 128'(32'h8000_0040));
    wait_idle("both_timeout", 40);
    chk("both_order_len", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() == 2) begin
      chk("both_first_lsu", 128'(grant_log[0]), 128'(32'h9000_0100));
      chk("both_then_ifu", 128'(grant_log[1]), 128'(32'h8000_0040));
    end
    if (lsu_res_data.size() > 0) chk("both_lsu_rdata", 128'(lsu_res_data[0]), 128'(mem_rd(32'h9000_0100)));

    // Continuous LSU traffic with IFU waiting; the previous test ended on an IFU grant, so the run count is 0
    logs_clear();
    for (int i = 0; i < 10; i++) begin
      op.w = bit'($urandom_range(0, 1)); op.addr = 32'h9000_0000 | (32'(i) << 4);
      op.data = $urandom; op.strb = 8'($urandom);
      lops.push_back(op); laddr.push_back(op.addr); lsu_q.push_back(op);
    end
    for (int i = 0; i < 3; i++) begin
      iaddr.push_back(32'h8000_1000 + 32'(i) * 4); ifu_q.push_back(32'h8000_1000 + 32'(i) * 4);
    end
    c = 0; li = 0; ii = 0;
    while (li < 10 || ii < 3) begin
      if (li < 10 && (ii >= 3 || c < int'(MAX_RUN))) begin
        exp_order.push_back(laddr[li]); li++;
        if (ii < 3 && c < int'(MAX_RUN)) c++;
      end else begin
        exp_order.push_back(iaddr[ii]); ii++; c = 0;
      end
    end
    drive(); #1;
    wait_idle("run_timeout", 400);
    chk("run_order_len", 128'(grant_log.size()), 128'(exp_order.size()));
    if (grant_log.size() == exp_order.size())
      foreach (exp_order[i]) chk($sformatf("run_order_%0d", i), 128'(grant_log[i]), 128'(exp_order[i]));
    chk("run_ifu_done", 128'(ifu_res_data.size()), 128'(3));
    foreach (ifu_res_data[i])
      if (i < ifu_res_addr.size()) chk($sformatf("run_ifu_rdata_%0d", i), 128'(ifu_res_data[i]), 128'(mem_rd(ifu_res_addr[i])));
    chk("run_lsu_done", 128'(lsu_res_data.size()), 128'(10));
    n = 0;
    foreach (lops[i]) begin
      if (i < lsu_res_data.size() && !lops[i].w)
        chk($sformatf("run_lsu_rdata_%0d", i), 128'(lsu_res_data[i]), 128'(mem_rd(lops[i].addr)));
      if (lops[i].w && n < sw_data.size()) begin
        chk($sformatf("run_wr_data_%0d", i), 128'({sw_addr[n], sw_data[n], sw_strb[n]}),
            128'({lops[i].addr, lops[i].data, lops[i].strb}));
        n++;
      end
    end

    // Error response on an LSU read is forwarded and the next read is normal
    logs_clear();
    op.w = 0; op.addr = 32'hE000_0010; lsu_q.push_back(op);
    op.addr = 32'h9000_0020; lsu_q.push_back(op);
    drive(); #1;
    wait_idle("err_timeout", 60);
    chk("err_count", 128'(lsu_res_resp.size()), 128'(2));
    if (lsu_res_resp.size() == 2) begin
      chk("err_rresp", 128'(lsu_res_resp[0]), 128'(2));
      chk("err_rdata", 128'(lsu_res_data[0]), 128'(mem_rd(32'hE000_0010)));
      chk("err_next_rresp", 128'(lsu_res_resp[1]), 128'(0));
      chk("err_next_rdata", 128'(lsu_res_data[1]), 128'(mem_rd(32'h9000_0020)));
    end

    // LSU read and write raised together: the read is granted
    force_both = 1; drive(); #1;
    cycle();
    chk("rw_read_wins_ar", 128'({s_arvalid, s_araddr}), 128'({1'b1, 32'h9000_0F00}));
    chk("rw_read_wins_aw", 128'({s_awvalid, lsu_awready, s_wvalid}), 128'(0));
    apply_reset();

    // Reset while waiting for B, then stray slave responses in IDLE
    fixed_lat = 8; logs_clear();
    op.w = 1; op.addr = 32'h9000_2000; op.data = 32'hCAFE_F00D; op.strb = 8'hf0;
    lsu_q.push_back(op); drive(); #1;
    n = 0;
    while (sst != 3 && n < 40) begin cycle(); n++; end
    chk("rstwr_reach_b_wait", 128'(n >= 40), 128'(0));
    cycle();
    chk("rstwr_bready_connected", 128'(s_bready), 128'(1));
    apply_reset();
    chk("rstwr_master_outs", mout(), 128'(0));
    chk("rstwr_slave_outs", sout(), 128'(0));
    stray_b = 1; drive(); #1;
    chk("stray_b_blocked", 128'({lsu_bvalid, lsu_bresp, s_bready}), 128'(0));
    cycle();
    chk("stray_b_still_blocked", 128'({lsu_bvalid, s_bready}), 128'(0));
    stray_b = 0; stray_r = 1; drive(); #1;
    chk("stray_r_blocked", 128'({ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, s_rready}), 128'(0));
    stray_r = 0; fixed_lat = -1; logs_clear();
    ifu_q.push_back(32'h8000_0100); drive(); #1;
    wait_idle("recover_timeout", 40);
    chk("recover_count", 128'(ifu_res_data.size()), 128'(1));
    if (ifu_res_data.size() > 0) chk("recover_rdata", 128'(ifu_res_data[0]), 128'(mem_rd(32'h8000_0100)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
